pc_dump_scheduler: RTL and testbench

Schedules performance-counter dumps to DDR. Queues dump requests (e.g. one per layer or tile-group completion) and issues them one at a time to the performance-counter writer through its `pc_start`/`pc_done` handshake. Gives each dump a distinct destination address from a circular slot table in DDR. Sits between the top-level controller and the performance-counter AXI write block, and replaces fixed per-dump address offsets with configurable base, slot count and stride.

---
 rtl/pc_dump_scheduler_if.sv | 38 +++
 rtl/pc_dump_scheduler.sv | 159 +++++++++++++++
 tb/tb_pc_dump_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_dump_scheduler_if.sv
// pc_dump_scheduler_if: bundles the controller-side config/request signals and
// the perf-counter writer handshake seen by pc_dump_scheduler.
// Ports (slave = scheduler): cfg_base_addr, cfg_num_slots, cfg_clear, dump_req,
// pc_done in; pc_start, pc_base_addr, busy, pending_cnt, slot_idx, dumps_total,
// overflow, timeout_err out. The master modport is the mirror image.
interface pc_dump_scheduler_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int MAX_SLOTS      = 16,
  parameter int PEND_WIDTH     = 4
) ();
  localparam int SLOT_W = $clog2(MAX_SLOTS);

  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr;
  logic [SLOT_W:0]           cfg_num_slots;
  logic                      cfg_clear;
  logic                      dump_req;
  logic                      pc_done;
  logic                      pc_start;
  logic [AXI_ADDR_WIDTH-1:0] pc_base_addr;
  logic                      busy;
  logic [PEND_WIDTH-1:0]     pending_cnt;
  logic [SLOT_W-1:0]         slot_idx;
  logic [31:0]               dumps_total;
  logic                      overflow;
  logic                      timeout_err;

  modport slave (
    input  cfg_base_addr, cfg_num_slots, cfg_clear, dump_req, pc_done,
    output pc_start, pc_base_addr, busy, pending_cnt, slot_idx, dumps_total,
           overflow, timeout_err
  );

  modport master (
    output cfg_base_addr, cfg_num_slots, cfg_clear, dump_req, pc_done,
    input  pc_start, pc_base_addr, busy, pending_cnt, slot_idx, dumps_total,
           overflow, timeout_err
  );
endinterface

// File: rtl/pc_dump_scheduler.sv
// pc_dump_scheduler: queues perf-counter dump requests and issues them one at a
//   time to the writer, each to the next slot of a circular DDR slot table.
// Latency: dump_req -> pc_start 2 cycles (idle, empty queue); pc_done -> next pc_start >= 3 cycles.
// Backpressure: none upstream; up to 2^PEND_WIDTH-1 requests queue, extras are dropped and flag overflow.
// Ports: clk_i, reset_i (synchronous, active-high); sched_if (slave modport of
//   pc_dump_scheduler_if) carrying config, dump_req, the pc_start/pc_done
//   handshake, pc_base_addr and status outputs.
// Build option: define PC_SCHED_TIMEOUT_EN to add the WAIT watchdog (TIMEOUT_CYCLES).
module pc_dump_scheduler #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int SLOT_BYTES     = 96,
  parameter int MAX_SLOTS      = 16,
  parameter int PEND_WIDTH     = 4
`ifdef PC_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic               clk_i,
  input  logic               reset_i,
  pc_dump_scheduler_if.slave sched_if
);

  localparam int SLOT_W = $clog2(MAX_SLOTS);
  localparam logic [PEND_WIDTH-1:0]     PEND_MAX    = {PEND_WIDTH{1'b1}};
  localparam logic [SLOT_W:0]           MAX_SLOTS_W = (SLOT_W+1)'(MAX_SLOTS);
  localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE      = AXI_ADDR_WIDTH'(SLOT_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ADVANCE} state_e;

  state_e                    state_q;
  logic                      pc_start_q;
  logic                      busy_q;
  logic                      overflow_q, overflow_d;
  logic [AXI_ADDR_WIDTH-1:0] pc_base_addr_q;
  logic [AXI_ADDR_WIDTH-1:0] slot_addr;
  logic [PEND_WIDTH-1:0]     pending_q, pending_d;
  logic [SLOT_W-1:0]         slot_q, slot_next;
  logic [SLOT_W:0]           eff_slots, slot_inc;
  logic [31:0]               dumps_q;
  logic                      issue;
  logic                      clear_ok;

`ifdef PC_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
`endif

  assign issue    = (state_q == S_ISSUE);
  // busy_q is low only in IDLE, so a clear can never cut a dump in half.
  assign clear_ok = sched_if.cfg_clear && !busy_q;

  // Pending queue depth: a request arriving with the ISSUE decrement cancels out,
  // so only a request against a full counter with no issue is dropped.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (clear_ok) begin
      pending_d  = PEND_WIDTH'(sched_if.dump_req);
      overflow_d = 1'b0;
    end else if (sched_if.dump_req && !issue) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + PEND_WIDTH'(1);
    end else if (!sched_if.dump_req && issue) begin
      pending_d = pending_q - PEND_WIDTH'(1);
    end
  end

  // Ring size clamp: 0 behaves as 1, oversize behaves as MAX_SLOTS.
  always_comb begin
    if (sched_if.cfg_num_slots == '0)              eff_slots = (SLOT_W+1)'(1);
    else if (sched_if.cfg_num_slots > MAX_SLOTS_W) eff_slots = MAX_SLOTS_W;
    else                                           eff_slots = sched_if.cfg_num_slots;
  end

  // Compare in SLOT_W+1 bits so slot_idx+1 == MAX_SLOTS does not alias to 0.
  assign slot_inc  = {1'b0, slot_q} + (SLOT_W+1)'(1);
  assign slot_next = (slot_inc >= eff_slots) ? '0 : slot_inc[SLOT_W-1:0];
  assign slot_addr = sched_if.cfg_base_addr + AXI_ADDR_WIDTH'(slot_q) * STRIDE;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      pc_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      pc_base_addr_q <= '0;
      pending_q      <= '0;
      slot_q         <= '0;
      dumps_q        <= '0;
`ifdef PC_SCHED_TIMEOUT_EN
      wd_q           <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pc_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (clear_ok) begin
            // Stay in IDLE this cycle; a queued request issues next cycle.
            slot_q  <= '0;
            dumps_q <= '0;
`ifdef PC_SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end else if (pending_q != '0) begin
            pc_base_addr_q <= slot_addr;
            pc_start_q     <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef PC_SCHED_TIMEOUT_EN
          wd_q    <= '0;
`endif
        end
        S_WAIT: begin
          if (sched_if.pc_done) begin
            state_q <= S_ADVANCE;
`ifdef PC_SCHED_TIMEOUT_EN
          end else if (wd_q == WD_LAST) begin
            // Give up on the writer but still consume the slot and count the dump.
            timeout_q <= 1'b1;
            state_q   <= S_ADVANCE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
`endif
          end
        end
        S_ADVANCE: begin
          slot_q  <= slot_next;
          dumps_q <= dumps_q + 32'd1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sched_if.pc_start     = pc_start_q;
  assign sched_if.pc_base_addr = pc_base_addr_q;
  assign sched_if.busy         = busy_q;
  assign sched_if.pending_cnt  = pending_q;
  assign sched_if.slot_idx     = slot_q;
  assign sched_if.dumps_total  = dumps_q;
  assign sched_if.overflow     = overflow_q;
`ifdef PC_SCHED_TIMEOUT_EN
  assign sched_if.timeout_err  = timeout_q;
`else
  assign sched_if.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_dump_scheduler.sv
// tb_pc_dump_scheduler: directed bench for pc_dump_scheduler with a small
// writer model that answers pc_start with pc_done after a programmable delay.
module tb_pc_dump_scheduler;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_dump_scheduler_if #(.AXI_ADDR_WIDTH(64), .MAX_SLOTS(16), .PEND_WIDTH(4)) ifc ();

  pc_dump_scheduler #(
    .AXI_ADDR_WIDTH(64),
    .SLOT_BYTES(96),
    .MAX_SLOTS(16),
    .PEND_WIDTH(4)
`ifdef PC_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .sched_if(ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // writer model state
  int done_dly    = 0;   // 0 = withhold pc_done
  int done_cd     = 0;
  int start_cnt   = 0;
  int viol        = 0;   // pc_start while a previous dump is outstanding
  int outstanding = 0;
  int cyc         = 0;
  int last_start  = -1000;
  int min_gap     = 1000;
  logic [63:0] addr_log [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    ifc.dump_req = 1'b1;
    tick(1);
    ifc.dump_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((ifc.busy || ifc.pending_cnt != 0) && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, (k < budget), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pc_start"},    ifc.pc_start, 0);
    check_eq({tag, "_pc_base"},     ifc.pc_base_addr, 0);
    check_eq({tag, "_busy"},        ifc.busy, 0);
    check_eq({tag, "_pending"},     ifc.pending_cnt, 0);
    check_eq({tag, "_slot"},        ifc.slot_idx, 0);
    check_eq({tag, "_dumps"},       ifc.dumps_total, 0);
    check_eq({tag, "_overflow"},    ifc.overflow, 0);
    check_eq({tag, "_timeout_err"}, ifc.timeout_err, 0);
  endtask

  // Writer model: pc_done done_dly cycles after pc_start, plus protocol monitor.
  initial begin
    ifc.pc_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ifc.pc_done = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin
          ifc.pc_done = 1'b1;
          outstanding = 0;
        end
      end
      if (ifc.pc_start === 1'b1) begin
        start_cnt++;
        addr_log.push_back(ifc.pc_base_addr);
        if (outstanding != 0) viol++;
        outstanding = 1;
        if (cyc - last_start < min_gap) min_gap = cyc - last_start;
        last_start = cyc;
        if (done_dly > 0) done_cd = done_dly;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "global timeout");
  end

  logic [63:0] exp_ring [5];
  int base_starts;
  int peak;

  initial begin
    exp_ring[0] = 64'h1000_0000;
    exp_ring[1] = 64'h1000_0060;
    exp_ring[2] = 64'h1000_00C0;
    exp_ring[3] = 64'h1000_0120;
    exp_ring[4] = 64'h1000_0000;

    reset             = 1'b1;
    ifc.cfg_base_addr = 64'h1000_0000;
    ifc.cfg_num_slots = 5'd4;
    ifc.cfg_clear     = 1'b0;
    ifc.dump_req      = 1'b0;
    done_dly          = 10;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(1);

    // ---- issue latency and completion timing on the first dump ----
    pulse_req();                                        // now t+1
    check_eq("lat_pend_t1", ifc.pending_cnt, 1);
    check_eq("lat_start_t1", ifc.pc_start, 0);
    check_eq("lat_busy_t1", ifc.busy, 0);
    tick(1);                                            // t+2
    check_eq("lat_start_t2", ifc.pc_start, 1);
    check_eq("lat_addr_t2", ifc.pc_base_addr, 64'h1000_0000);
    check_eq("lat_busy_t2", ifc.busy, 1);
    tick(1);                                            // t+3
    check_eq("lat_pend_t3", ifc.pending_cnt, 0);
    check_eq("lat_start_t3", ifc.pc_start, 0);
    tick(9);                                            // pc_done cycle
    check_eq("done_cycle_dumps", ifc.dumps_total, 0);
    check_eq("done_cycle_busy", ifc.busy, 1);
    tick(2);                                            // d+2: IDLE, counters updated
    check_eq("done_d2_busy", ifc.busy, 0);
    check_eq("done_d2_dumps", ifc.dumps_total, 1);
    check_eq("done_d2_slot", ifc.slot_idx, 1);

    // ---- ring wrap ----
    for (int i = 0; i < 4; i++) begin
      pulse_req();
      wait_idle(100, "ring_idle");
    end
    check_eq("ring_nstart", addr_log.size(), 5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++)
      check_eq($sformatf("ring_addr%0d", i), addr_log[i], exp_ring[i]);
    check_eq("ring_dumps", ifc.dumps_total, 5);
    check_eq("ring_slot", ifc.slot_idx, 1);

    // ---- queueing: three back-to-back requests ----
    done_dly    = 3;
    base_starts = start_cnt;
    peak        = 0;
    for (int i = 0; i < 3; i++) begin
      ifc.dump_req = 1'b1;
      tick(1);
      if (ifc.pending_cnt > peak) peak = ifc.pending_cnt;
    end
    ifc.dump_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (ifc.pending_cnt > peak) peak = ifc.pending_cnt;
    end
    check_eq("queue_peak", peak, 2);
    wait_idle(200, "queue_idle");
    check_eq("queue_nstart", start_cnt - base_starts, 3);
    check_eq("queue_overflow", ifc.overflow, 0);
    check_eq("queue_order_viol", viol, 0);

    // ---- overflow: 17 requests with pc_done withheld ----
    done_dly    = 0;
    base_starts = start_cnt;
    for (int i = 0; i < 17; i++) begin
      ifc.dump_req = 1'b1;
      tick(1);
    end
    ifc.dump_req = 1'b0;
    tick(2);
    check_eq("ovf_pending", ifc.pending_cnt, 15);
    check_eq("ovf_flag", ifc.overflow, 1);
    check_eq("ovf_nstart", start_cnt - base_starts, 1);
    check_eq("ovf_busy", ifc.busy, 1);
    min_gap  = 1000;
    done_dly = 1;
    done_cd  = 1;
    wait_idle(400, "ovf_drain_idle");
    check_eq("ovf_drain_nstart", start_cnt - base_starts, 16);
    check_eq("ovf_dumps", ifc.dumps_total, 24);
    check_eq("ovf_slot", ifc.slot_idx, 0);
    check_eq("ovf_min_spacing", min_gap, 4);
    check_eq("ovf_order_viol", viol, 0);

    // ---- cfg_clear while idle, with a dump_req in the same cycle ----
    done_dly      = 3;
    ifc.cfg_clear = 1'b1;
    ifc.dump_req  = 1'b1;
    tick(1);
    ifc.cfg_clear = 1'b0;
    ifc.dump_req  = 1'b0;
    check_eq("clr_overflow", ifc.overflow, 0);
    check_eq("clr_dumps", ifc.dumps_total, 0);
    check_eq("clr_slot", ifc.slot_idx, 0);
    check_eq("clr_pending", ifc.pending_cnt, 1);
    check_eq("clr_busy", ifc.busy, 0);
    tick(1);
    check_eq("clr_start", ifc.pc_start, 1);
    check_eq("clr_addr", ifc.pc_base_addr, 64'h1000_0000);
    wait_idle(100, "clr_idle");

    // ---- dump_req in the ISSUE cycle; cfg_clear while busy ----
    base_starts = start_cnt;
    pulse_req();                                        // t+1
    tick(1);                                            // t+2, ISSUE
    check_eq("sim_start", ifc.pc_start, 1);
    ifc.dump_req = 1'b1;
    tick(1);
    ifc.dump_req = 1'b0;
    check_eq("sim_pending", ifc.pending_cnt, 1);
    ifc.cfg_clear = 1'b1;
    tick(1);
    ifc.cfg_clear = 1'b0;
    check_eq("busyclr_pending", ifc.pending_cnt, 1);
    check_eq("busyclr_dumps", ifc.dumps_total, 1);
    check_eq("busyclr_busy", ifc.busy, 1);
    wait_idle(100, "sim_idle");
    check_eq("sim_nstart", start_cnt - base_starts, 2);
    check_eq("sim_dumps", ifc.dumps_total, 3);
    check_eq("sim_slot", ifc.slot_idx, 3);

    // ---- WAIT without pc_done ----
    done_dly = 0;
    pulse_req();
    tick(1);
    check_eq("wd_start", ifc.pc_start, 1);
`ifdef PC_SCHED_TIMEOUT_EN
    tick(64);
    check_eq("wd_pre_busy", ifc.busy, 1);
    check_eq("wd_pre_err", ifc.timeout_err, 0);
    tick(2);
    check_eq("wd_busy", ifc.busy, 0);
    check_eq("wd_err", ifc.timeout_err, 1);
    check_eq("wd_slot", ifc.slot_idx, 0);
    check_eq("wd_dumps", ifc.dumps_total, 4);
    outstanding = 0;
    pulse_req();
    tick(3);
`else
    tick(1000);
    check_eq("nowd_busy", ifc.busy, 1);
    check_eq("nowd_err", ifc.timeout_err, 0);
    check_eq("nowd_dumps", ifc.dumps_total, 3);
    check_eq("nowd_slot", ifc.slot_idx, 3);
`endif

    // ---- reset mid-WAIT, then a late pc_done ----
    check_eq("rst_pre_busy", ifc.busy, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_all_zero("rst_mid");
    base_starts = start_cnt;
    done_cd     = 2;
    tick(6);
    check_eq("late_done_dumps", ifc.dumps_total, 0);
    check_eq("late_done_busy", ifc.busy, 0);
    check_eq("late_done_slot", ifc.slot_idx, 0);
    check_eq("late_done_nstart", start_cnt - base_starts, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
